// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams (x, w) pairs through a 2x2-bit multiplier and
// accumulates the products of one job into a saturating signed accumulator.

module mult (
  input  logic [1:0]        x,
  input  logic [1:0]        w,
  output logic signed [3:0] p
);
  logic signed [3:0] xs;
  logic signed [3:0] ws;

  // x is unsigned 0..3, w is signed -2..1; the product always fits 4 bits.
  assign xs = {2'b00, x};
  assign ws = {{2{w[1]}}, w};
  assign p  = xs * ws;
endmodule

module mac_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              x,
  input  logic [1:0]              w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] result,
  output logic                    sat,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   state;
  logic [LEN_W-1:0]         remaining;
  logic signed [3:0]        prod;
  logic signed [3:0]        mult_p;
  logic                     p_valid;
  logic signed [ACC_W-1:0]  acc;
  logic                     sat_r;
  logic [ACC_W:0]           sum;
  logic                     ovf_hi;
  logic                     ovf_lo;
  logic [ACC_W-1:0]         acc_sat;

  mult u_mult (
    .x (x),
    .w (w),
    .p (mult_p)
  );

  // Handshakes: a transfer happens at a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready depends only on state.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign result    = acc;
  assign sat       = sat_r;
  assign state_dbg = state;

  // One guard bit catches overflow; the two top bits disagree only on overflow.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W-3){prod[3]}}, prod};
    ovf_hi  = ~sum[ACC_W] &  sum[ACC_W-1];
    ovf_lo  =  sum[ACC_W] & ~sum[ACC_W-1];
    acc_sat = sum[ACC_W-1:0];
    if (ovf_hi) acc_sat = ACC_MAX;
    if (ovf_lo) acc_sat = ACC_MIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      prod      <= '0;
      p_valid   <= 1'b0;
      acc       <= '0;
      sat_r     <= 1'b0;
    end else begin
      if (p_valid && (state == RUN || state == DRAIN)) begin
        acc <= acc_sat;
        if (ovf_hi || ovf_lo) sat_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          p_valid <= 1'b0;
          if (start) begin
            acc   <= '0;
            sat_r <= 1'b0;
            if (len != '0) begin
              remaining <= len;
              state     <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            prod      <= mult_p;
            p_valid   <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end else begin
            p_valid <= 1'b0;
          end
        end
        DRAIN: begin
          p_valid <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: hand-computed dot products, saturation,
// empty jobs, result hold in DONE and mid-job reset.

module tb_mac_seq_ctrl;

  localparam int LEN_W = 8;
  localparam int ACC_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       x;
  logic [1:0]       w;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             sat;
  logic [1:0]       state_dbg;

  // Expected {sat, result} per job, pushed at start, popped at completion.
  logic [ACC_W:0] exp_q[$];

  int n_cmp;
  int n_err;

  mac_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Driver tasks: inputs change #1 after a rising edge, outputs are sampled
  // on the falling edge.
  task automatic start_job(input logic [LEN_W-1:0] l, input logic [ACC_W:0] exp);
    exp_q.push_back(exp);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed_pair(input string tag, input logic [1:0] xv, input logic [1:0] wv);
    int t;
    t = 0;
    in_valid = 1'b1;
    x = xv;
    w = wv;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(tag, in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the completed job against the head of exp_q.
  task automatic wait_result(input string tag);
    logic [ACC_W:0] e;
    int t;
    t = 0;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else check({tag, "_sb_underflow"}, 1, 0);
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, e[ACC_W-1:0]);
    check({tag, "_sat"}, sat, e[ACC_W]);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    x = '0;
    w = '0;
    out_ready = 1'b0;

    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_sat", sat, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clk);
    #1;

    // 3 + 2 - 1 - 6 = -2, in_valid held high
    start_job(4, {1'b0, 8'hFE});
    feed_pair("j1_p0", 2'd3, 2'b01);
    feed_pair("j1_p1", 2'd2, 2'b01);
    feed_pair("j1_p2", 2'd1, 2'b11);
    feed_pair("j1_p3", 2'd3, 2'b10);
    in_valid = 1'b0;
    @(negedge clk);
    check("j1_drain_out_valid", out_valid, 0);
    check("j1_drain_busy", busy, 1);
    @(negedge clk);
    check("j1_latency_out_valid", out_valid, 1);
    wait_result("j1");

    // Gapped stream, 3 accepts of 3*1, then an extra pair must be refused
    start_job(3, {1'b0, 8'd9});
    feed_pair("j2_p0", 2'd3, 2'b01);
    idle_cycle();
    feed_pair("j2_p1", 2'd3, 2'b01);
    idle_cycle();
    feed_pair("j2_p2", 2'd3, 2'b01);
    in_valid = 1'b1;
    x = 2'd2;
    w = 2'b01;
    @(negedge clk);
    check("j2_no_4th_ready", in_ready, 0);
    wait_result("j2");
    check("j2_done_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // 30 * -6 clamps to -128
    start_job(30, {1'b1, 8'h80});
    for (int i = 0; i < 30; i++) feed_pair("j3_p", 2'd3, 2'b10);
    in_valid = 1'b0;
    wait_result("j3");

    // 50 * 3 clamps to +127; acc and sat were cleared by start
    start_job(50, {1'b1, 8'h7F});
    for (int i = 0; i < 50; i++) feed_pair("j4_p", 2'd3, 2'b01);
    in_valid = 1'b0;
    wait_result("j4");

    start_job(1, {1'b0, 8'd1});
    feed_pair("j5_p", 2'd1, 2'b01);
    in_valid = 1'b0;
    wait_result("j5");

    // Empty job goes straight to DONE
    start_job(0, {1'b0, 8'd0});
    @(negedge clk);
    check("j6_out_valid", out_valid, 1);
    check("j6_in_ready", in_ready, 0);
    check("j6_state", state_dbg, 3);
    wait_result("j6");

    // Hold in DONE while start pulses are ignored: 2*1 = 2
    start_job(1, {1'b0, 8'd2});
    feed_pair("j7_p", 2'd2, 2'b01);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len = 8'd5;
      check("j7_hold_valid", out_valid, 1);
      check("j7_hold_result", result, 2);
      check("j7_hold_busy", busy, 1);
      check("j7_hold_state", state_dbg, 3);
      @(negedge clk);
    end
    start = 1'b0;
    wait_result("j7");
    @(negedge clk);
    check("j7_idle_busy", busy, 0);
    check("j7_idle_state", state_dbg, 0);
    @(posedge clk);
    #1;

    // Reset after 2 of 4 pairs; the aborted job leaves nothing behind
    start = 1'b1;
    len = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    feed_pair("j8_p0", 2'd3, 2'b01);
    feed_pair("j8_p1", 2'd3, 2'b01);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("j8_rst_busy", busy, 0);
    check("j8_rst_in_ready", in_ready, 0);
    check("j8_rst_out_valid", out_valid, 0);
    check("j8_rst_result", result, 0);
    check("j8_rst_sat", sat, 0);
    check("j8_rst_state", state_dbg, 0);
    @(posedge clk);
    #1;
    start_job(2, {1'b0, 8'd2});
    feed_pair("j9_p0", 2'd1, 2'b01);
    feed_pair("j9_p1", 2'd1, 2'b01);
    in_valid = 1'b0;
    wait_result("j9");

    check("sb_empty", exp_q.size(), 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
